// File: rtl/sfq_and_driver.sv
// sfq_and_driver
// Stimulus driver and checker for a clocked SFQ AND cell. Turns a command
// stream into toggle-encoded pulses (one pulse = one level flip) on the
// cell's a, b and clock lines. It tracks the cell's stored-input state so
// that a second pulse on an input that is already stored is never issued,
// because that would put the cell into its error state. After every
// cell-clock pulse it compares the returned out level against its own
// prediction.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  driver can accept a command (high only in IDLE)
//   cmd_op     00=pulse a, 01=pulse b, 10=pulse cell clock, 11=no-op
//   cmd_gap    idle cycles to insert after the command
//   a_o        toggle-encoded line to cell input a
//   b_o        toggle-encoded line to cell input b
//   sclk_o     toggle-encoded line to cell clock
//   dut_out    toggle-encoded cell output level
//   exp_state  model state: bit0 = a stored, bit1 = b stored
//   exp_out    predicted level of dut_out
//   err        sticky mismatch flag
//   err_cnt    saturating mismatch count
//   skip_cnt   saturating suppressed-pulse count
//   fire_cnt   saturating count of cell-clock pulses issued with a and b stored
//
// State | meaning
// IDLE  | waiting for a command, cmd_ready high
// GAP   | post-command idle time, counter holds remaining cycles
// CHECK | waiting for the cell output to settle before comparing
module sfq_and_driver #(
    parameter int GAP_W     = 4,
    parameter int CHECK_DLY = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             a_o,
    output logic             b_o,
    output logic             sclk_o,
    input  logic             dut_out,
    output logic [1:0]       exp_state,
    output logic             exp_out,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] fire_cnt
);

    // One counter serves both CHECK and GAP, so it must hold either value.
    localparam int CW = (GAP_W > 4) ? GAP_W : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               a_d, b_d, sclk_d, out_d, err_d;
    logic [1:0]         st_d;
    logic [CNT_W-1:0]   err_cnt_d, skip_cnt_d, fire_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cmd_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            sclk_o    <= 1'b0;
            exp_state <= 2'b00;
            exp_out   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            skip_cnt  <= '0;
            fire_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            a_o       <= a_d;
            b_o       <= b_d;
            sclk_o    <= sclk_d;
            exp_state <= st_d;
            exp_out   <= out_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
            skip_cnt  <= skip_cnt_d;
            fire_cnt  <= fire_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        a_d        = a_o;
        b_d        = b_o;
        sclk_d     = sclk_o;
        st_d       = exp_state;
        out_d      = exp_out;
        err_d      = err;
        err_cnt_d  = err_cnt;
        skip_cnt_d = skip_cnt;
        fire_cnt_d = fire_cnt;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    gap_d = cmd_gap;
                    case (cmd_op)
                        2'b00: begin
                            if (!exp_state[0]) begin
                                a_d     = ~a_o;
                                st_d[0] = 1'b1;
                            end else begin
                                skip_cnt_d = sat_inc(skip_cnt);
                            end
                        end
                        2'b01: begin
                            if (!exp_state[1]) begin
                                b_d     = ~b_o;
                                st_d[1] = 1'b1;
                            end else begin
                                skip_cnt_d = sat_inc(skip_cnt);
                            end
                        end
                        2'b10: begin
                            sclk_d = ~sclk_o;
                            // The cell only fires when both inputs are stored;
                            // either way the clock pulse empties it.
                            if (exp_state == 2'b11) begin
                                out_d      = ~exp_out;
                                fire_cnt_d = sat_inc(fire_cnt);
                            end
                            st_d    = 2'b00;
                            cnt_d   = CW'(CHECK_DLY);
                            state_d = CHECK;
                        end
                        default: ;
                    endcase
                    if (cmd_op != 2'b10 && cmd_gap != '0) begin
                        cnt_d   = CW'(cmd_gap);
                        state_d = GAP;
                    end
                end
            end
            CHECK: begin
                cnt_d = cnt_q - 1'b1;
                // Counter reaches zero on this edge: sample the cell output now.
                if (cnt_q == CW'(1)) begin
                    if (dut_out != exp_out) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt);
                    end
                    if (gap_q != '0) begin
                        cnt_d   = CW'(gap_q);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
